// File: rtl/out_bus_arbiter.sv
// out_bus_arbiter: round-robin arbiter that hands one registered output bus to one requester at a time.
// Optional forced-revoke timeout is built only when OUT_BUS_ARBITER_TIMEOUT_EN is defined.
module out_bus_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 16,
  parameter int HOLD_MAX = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ-1:0]        wvalid,
  input  logic [NUM_REQ*DATA_W-1:0] wdata,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [2:0]                owner,
  output logic                      busy,
  output logic [DATA_W-1:0]         out1,
  output logic                      out_valid,
  output logic                      timeout
);

  localparam int IDX_W = (NUM_REQ > 2) ? $clog2(NUM_REQ) : 1;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GRANT = 2'd1;
  localparam logic [1:0] ST_DRAIN = 2'd2;

  localparam logic [NUM_REQ-1:0] GNT_ONE  = {{(NUM_REQ-1){1'b0}}, 1'b1};
  localparam logic [NUM_REQ-1:0] GNT_NONE = {NUM_REQ{1'b0}};
  localparam logic [IDX_W-1:0]   IDX_LAST = IDX_W'(NUM_REQ - 1);
  localparam logic [IDX_W-1:0]   IDX_ZERO = {IDX_W{1'b0}};

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("out_bus_arbiter: NUM_REQ must be in 2..8");
  end
  if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
    $error("out_bus_arbiter: HOLD_MAX must be in 1..255");
  end

  // First candidate at or above start, wrapping past the top index.
  function automatic logic [IDX_W-1:0] rr_pick(input logic [NUM_REQ-1:0] cand,
                                               input logic [IDX_W-1:0]   start);
    logic [IDX_W-1:0] pick;
    logic [IDX_W-1:0] idx;
    logic             found;
    pick  = start;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      idx = IDX_W'((int'(start) + i) % NUM_REQ);
      if (!found && cand[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
    end
    return pick;
  endfunction

  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] cur);
    return (cur == IDX_LAST) ? IDX_ZERO : cur + IDX_W'(1);
  endfunction

  logic [1:0]          state_r, state_s;
  logic [IDX_W-1:0]    rr_r, rr_s;
  logic [IDX_W-1:0]    own_r, own_s;
  logic [NUM_REQ-1:0]  gnt_r, gnt_s;
  logic                busy_r, busy_s;
  logic [DATA_W-1:0]   out1_r;
  logic                out_valid_r;
  logic                load_s;
  logic                revoke_s;
  logic                hold_hit_s;
  logic [NUM_REQ-1:0]  mask_s;
  logic [NUM_REQ-1:0]  cand_s;
  logic [DATA_W-1:0]   wd_s [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_wd
    assign wd_s[i] = wdata[i*DATA_W +: DATA_W];
  end

`ifdef OUT_BUS_ARBITER_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);

  logic [7:0]         hold_r;
  logic [NUM_REQ-1:0] mask_r;
  logic               timeout_r;

  assign hold_hit_s = req[own_r] && (hold_r == HOLD_LAST);
  assign mask_s     = mask_r;
  assign timeout    = timeout_r;

  // Hold counter, revoke pulse, and re-request mask for revoked owners.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hold_r    <= 8'd0;
      mask_r    <= GNT_NONE;
      timeout_r <= 1'b0;
    end else begin
      hold_r    <= (state_r == ST_GRANT) ? hold_r + 8'd1 : 8'd0;
      mask_r    <= (mask_r & req) | (revoke_s ? (GNT_ONE << own_r) : GNT_NONE);
      timeout_r <= revoke_s;
    end
  end
`else
  assign hold_hit_s = 1'b0;
  assign mask_s     = GNT_NONE;
  assign timeout    = 1'b0;
`endif

  assign cand_s = req & ~mask_s;

  // Next-state, grant selection and write-capture decision.
  always_comb begin
    state_s  = state_r;
    rr_s     = rr_r;
    own_s    = own_r;
    gnt_s    = gnt_r;
    busy_s   = busy_r;
    load_s   = 1'b0;
    revoke_s = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (|cand_s) begin
          own_s   = rr_pick(cand_s, rr_r);
          gnt_s   = GNT_ONE << own_s;
          busy_s  = 1'b1;
          state_s = ST_GRANT;
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_GRANT: begin
        revoke_s = hold_hit_s;
        // A write in the release cycle still lands; a write in the revoke cycle does not.
        load_s   = wvalid[own_r] && !hold_hit_s;
        if (!req[own_r] || hold_hit_s) begin
          gnt_s   = GNT_NONE;
          busy_s  = 1'b0;
          rr_s    = next_idx(own_r);
          state_s = ST_DRAIN;
        end else begin
          state_s = ST_GRANT;
        end
      end
      ST_DRAIN: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
        gnt_s   = GNT_NONE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State, grant and shared output register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r     <= ST_IDLE;
      rr_r        <= IDX_ZERO;
      own_r       <= IDX_ZERO;
      gnt_r       <= GNT_NONE;
      busy_r      <= 1'b0;
      out1_r      <= {DATA_W{1'b0}};
      out_valid_r <= 1'b0;
    end else begin
      state_r     <= state_s;
      rr_r        <= rr_s;
      own_r       <= own_s;
      gnt_r       <= gnt_s;
      busy_r      <= busy_s;
      out_valid_r <= load_s;
      if (load_s) begin
        out1_r <= wd_s[own_r];
      end
    end
  end

  assign gnt       = gnt_r;
  assign owner     = 3'(own_r);
  assign busy      = busy_r;
  assign out1      = out1_r;
  assign out_valid = out_valid_r;

endmodule

// File: tb/tb_out_bus_arbiter.sv
// Randomized bench for out_bus_arbiter against a cycle-level ownership model.
module tb_out_bus_arbiter;

  localparam int N    = 4;
  localparam int W    = 16;
  localparam int HOLD = 8;
`ifdef OUT_BUS_ARBITER_TIMEOUT_EN
  localparam bit TMO_EN = 1'b1;
`else
  localparam bit TMO_EN = 1'b0;
`endif

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req = '0;
  logic [N-1:0]   wvalid = '0;
  logic [W-1:0]   wd_a [N];
  logic [N*W-1:0] wdata;
  logic [N-1:0]   gnt;
  logic [2:0]     owner;
  logic           busy;
  logic [W-1:0]   out1;
  logic           out_valid;
  logic           timeout;

  int checks = 0;
  int errors = 0;

  // Model: who owns the bus, how long until a new grant is allowed, where the search starts.
  int           m_owner;
  int           m_gap;
  int           m_held;
  logic [1:0]   m_start;
  logic [N-1:0] m_blocked;
  logic [W-1:0] m_out1;
  bit           m_valid;
  bit           m_tmo;

  int         t_gnt, t_tmo, regrant0, ngr;
  logic [2:0] got_order [5];
  bit         prev_busy;

  assign wdata = {wd_a[3], wd_a[2], wd_a[1], wd_a[0]};

  out_bus_arbiter #(.NUM_REQ(N), .DATA_W(W), .HOLD_MAX(HOLD)) dut (
    .clk       (clk),
    .reset     (reset),
    .req       (req),
    .wvalid    (wvalid),
    .wdata     (wdata),
    .gnt       (gnt),
    .owner     (owner),
    .busy      (busy),
    .out1      (out1),
    .out_valid (out_valid),
    .timeout   (timeout)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_owner   = -1;
    m_gap     = 0;
    m_held    = 0;
    m_start   = 2'd0;
    m_blocked = '0;
    m_out1    = '0;
    m_valid   = 1'b0;
    m_tmo     = 1'b0;
  endtask

  task automatic model_step();
    logic [1:0] o;
    logic [1:0] c;
    bit         hit;
    m_valid = 1'b0;
    m_tmo   = 1'b0;
    if (m_owner >= 0) begin
      o   = 2'(m_owner);
      hit = TMO_EN && req[o] && (m_held + 1 == HOLD);
      if (wvalid[o] && !hit) begin
        m_out1  = wd_a[o];
        m_valid = 1'b1;
      end
      if (!req[o] || hit) begin
        m_tmo = hit;
        if (hit) m_blocked[o] = 1'b1;
        m_start = o + 2'd1;
        m_owner = -1;
        m_gap   = 1;
      end else begin
        m_held++;
      end
    end else if (m_gap > 0) begin
      m_gap--;
    end else begin
      for (int k = 0; k < N; k++) begin
        c = 2'(int'(m_start) + k);
        if (m_owner < 0 && req[c] && !m_blocked[c]) begin
          m_owner = int'(c);
          m_held  = 0;
        end
      end
    end
    for (int i = 0; i < N; i++) begin
      if (!req[2'(i)]) m_blocked[2'(i)] = 1'b0;
    end
  endtask

  task automatic compare_all();
    logic [N-1:0] eg;
    eg = (m_owner >= 0) ? (4'b0001 << m_owner) : 4'b0000;
    check("gnt", 32'(gnt), 32'(eg));
    check("busy", 32'(busy), 32'(m_owner >= 0));
    if (m_owner >= 0) check("owner", 32'(owner), 32'(m_owner));
    check("out1", 32'(out1), 32'(m_out1));
    check("out_valid", 32'(out_valid), 32'(m_valid));
    check("timeout", 32'(timeout), 32'(m_tmo));
  endtask

  task automatic step();
    @(posedge clk);
    model_step();
    #1;
    compare_all();
  endtask

  task automatic apply_reset();
    reset  = 1'b0;
    req    = '0;
    wvalid = '0;
    for (int i = 0; i < N; i++) wd_a[i] = '0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    compare_all();
    reset = 1'b1;
  endtask

  initial begin
    for (int i = 0; i < N; i++) wd_a[i] = '0;
    model_reset();
    apply_reset();

    // Idle with no requests.
    repeat (10) step();

    // Single owner write.
    req = 4'b0100;
    step();
    check("dir_gnt", 32'(gnt), 32'(4'b0100));
    wvalid   = 4'b0100;
    wd_a[2]  = 16'h0123;
    step();
    check("dir_out1", 32'(out1), 32'(16'h0123));
    check("dir_valid", 32'(out_valid), 32'(1'b1));
    wvalid = '0;
    step();
    check("dir_valid_off", 32'(out_valid), 32'(1'b0));
    step();

    // Asynchronous reset between edges while requester 2 owns the bus.
    #3 reset = 1'b0;
    #1;
    model_reset();
    check("areset_gnt", 32'(gnt), 32'(4'b0000));
    check("areset_out1", 32'(out1), 32'(16'h0000));
    check("areset_busy", 32'(busy), 32'(1'b0));
    req = '0;
    @(posedge clk);
    #1 reset = 1'b1;

    // Non-owner writes are ignored; the waiting requester is held off.
    req = 4'b1010;
    step();
    wvalid  = 4'b1010;
    wd_a[1] = 16'h0ABC;
    wd_a[3] = 16'hFFFF;
    step();
    check("iso_out1", 32'(out1), 32'(16'h0ABC));
    wvalid = '0;
    repeat (3) begin
      step();
      check("iso_gnt3_wait", 32'(gnt[3]), 32'(1'b0));
    end
    req = 4'b1000;
    repeat (3) step();
    check("iso_gnt3_after", 32'(gnt[3]), 32'(1'b1));
    req = '0;
    repeat (3) step();

    // Long hold by requester 0 with requester 1 waiting.
    req      = 4'b0011;
    t_gnt    = -1;
    t_tmo    = -1;
    regrant0 = 0;
    for (int i = 0; i < 30; i++) begin
      step();
      if (t_gnt < 0 && busy) t_gnt = i;
      if (t_tmo < 0 && timeout) t_tmo = i;
      if (t_tmo >= 0 && i > t_tmo && gnt[0]) regrant0++;
    end
`ifdef OUT_BUS_ARBITER_TIMEOUT_EN
    check("tmo_latency", 32'(t_tmo - t_gnt), 32'(HOLD));
    check("tmo_no_regrant0", 32'(regrant0), 32'(0));
`else
    check("hold_no_tmo", 32'(t_tmo), 32'(-1));
`endif
    req = 4'b0010;
    step();
    req = 4'b0011;
    repeat (12) step();

    // Fairness: all request, each owner releases three cycles after its grant.
    apply_reset();
    req       = 4'b1111;
    ngr       = 0;
    prev_busy = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (busy && !prev_busy && ngr < 5) begin
        got_order[ngr] = owner;
        ngr++;
      end
      prev_busy = busy;
      req = 4'b1111;
      if (m_owner >= 0 && m_held == 2) req[2'(m_owner)] = 1'b0;
    end
    check("rr_count", 32'(ngr), 32'(5));
    for (int k = 0; k < 5; k++) check("rr_order", 32'(got_order[k]), 32'(k % N));

    // Randomized traffic.
    apply_reset();
    for (int i = 0; i < 3000; i++) begin
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(5, 0) == 0) req[2'(b)] = ~req[2'(b)];
      end
      wvalid = 4'($urandom);
      for (int b = 0; b < N; b++) wd_a[b] = 16'($urandom);
      step();
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
